// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and downstream memory signals for mem_port_arbiter.
// slave is the arbiter's view; master is the core/memory-model side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;

  logic        dm_req;
  logic        dm_we;
  logic [2:0]  dm_type;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_err;
  logic        dm_stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, if_stall,
    input  dm_req, dm_we, dm_type, dm_addr, dm_wdata,
    output dm_rdata, dm_valid, dm_err, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, if_stall,
    output dm_req, dm_we, dm_type, dm_addr, dm_wdata,
    input  dm_rdata, dm_valid, dm_err, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, with
// byte strobes, load extension, misalignment detection and fetch-starvation guard.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rstn,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_I_WAIT = 2'd1;
  localparam logic [1:0] S_D_WAIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]  state;
  logic [3:0]  starve_cnt;
  logic        drop;
  logic        done_if;
  logic        err_q;
  logic [2:0]  ld_type;
  logic [1:0]  ld_off;
  logic [31:0] rdata_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;

  logic        if_ok;
  logic        if_force;
  logic        misaligned;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign if_ok    = bus.if_req & ~bus.if_flush;
  assign if_force = if_ok && (starve_cnt == STARVE_LIM);

  always_comb begin
    misaligned = 1'b0;
    st_strb    = 4'b1111;
    st_wdata   = bus.dm_wdata;
    case (bus.dm_type[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << bus.dm_addr[1:0];
        st_wdata = {4{bus.dm_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = bus.dm_addr[0];
        st_strb    = 4'b0011 << {bus.dm_addr[1], 1'b0};
        st_wdata   = {2{bus.dm_wdata[15:0]}};
      end
      default: misaligned = (bus.dm_addr[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      starve_cnt  <= '0;
      drop        <= 1'b0;
      done_if     <= 1'b0;
      err_q       <= 1'b0;
      ld_type     <= '0;
      ld_off      <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          drop <= 1'b0;
          if (bus.dm_req && !if_force) begin
            done_if <= 1'b0;
            ld_type <= bus.dm_type;
            ld_off  <= bus.dm_addr[1:0];
            // saturate so a flushed fetch cannot wrap the counter past the limit
            if (!bus.if_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 4'd1;
            if (misaligned) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= S_DONE;
            end else begin
              err_q       <= 1'b0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.dm_we;
              mem_addr_q  <= {bus.dm_addr[31:2], 2'b00};
              mem_wdata_q <= st_wdata;
              mem_wstrb_q <= bus.dm_we ? st_strb : 4'b0000;
              state       <= S_D_WAIT;
            end
          end else if (if_ok) begin
            done_if     <= 1'b1;
            err_q       <= 1'b0;
            starve_cnt  <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr & ~32'd3;
            mem_wstrb_q <= 4'b0000;
            state       <= S_I_WAIT;
          end
        end
        S_I_WAIT, S_D_WAIT: begin
          if (state == S_I_WAIT && bus.if_flush)
            drop <= 1'b1;
          if (bus.mem_ack) begin
            rdata_q   <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            state     <= S_DONE;
          end
        end
        default: begin
          drop  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    case (ld_off)
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      2'd3:    ld_byte = rdata_q[31:24];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = ld_off[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (ld_type)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  // a flush arriving in the completion cycle still kills the fetch result
  assign bus.if_valid  = (state == S_DONE) & done_if & ~drop & ~bus.if_flush;
  assign bus.dm_valid  = (state == S_DONE) & ~done_if;
  assign bus.dm_err    = bus.dm_valid & err_q;
  assign bus.if_rdata  = rdata_q;
  assign bus.dm_rdata  = (bus.dm_valid && !err_q) ? ld_ext : '0;
  assign bus.if_stall  = rstn & bus.if_req & ~bus.if_valid;
  assign bus.dm_stall  = rstn & bus.dm_req & ~bus.dm_valid;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected bus transactions and completions
// are queued as stimulus is driven and checked as the DUT produces them.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_port_arbiter_if mi();

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (mi)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    bit          chk_wd;
  } bus_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    bit          chk_rd;
  } dm_t;

  bus_t        bus_q[$];
  dm_t         dm_q[$];
  logic [31:0] if_q[$];
  bit          port_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_delay = 0;
  logic [31:0] rd_word = '0;
  int          if_valid_cnt = 0;
  int          dm_valid_cnt = 0;
  int          mem_req_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory model: ack after ack_delay extra cycles of mem_req
  initial begin
    int wcnt;
    wcnt = 0;
    mi.mem_ack   = 1'b0;
    mi.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mi.mem_ack = 1'b0;
      if (rstn === 1'b1 && mi.mem_req === 1'b1) begin
        wcnt++;
        if (wcnt > ack_delay) begin
          mi.mem_ack   = 1'b1;
          mi.mem_rdata = rd_word;
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // monitor: pops expectations when the DUT completes bus or port transactions
  initial begin
    bus_t b;
    dm_t  d;
    bit   p;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        if (mi.mem_req === 1'b1) mem_req_cycles++;
        if (mi.mem_req === 1'b1 && mi.mem_ack === 1'b1) begin
          if (bus_q.size() == 0) check_eq("bus_unexpected", 1, 0);
          else begin
            b = bus_q.pop_front();
            check_eq("mem_addr", mi.mem_addr, b.addr);
            check_eq("mem_we", {31'd0, mi.mem_we}, {31'd0, b.we});
            check_eq("mem_wstrb", {28'd0, mi.mem_wstrb}, {28'd0, b.strb});
            if (b.chk_wd) check_eq("mem_wdata", mi.mem_wdata, b.wdata);
          end
        end
        if (mi.if_valid === 1'b1 || mi.dm_valid === 1'b1) begin
          if (port_q.size() == 0) check_eq("valid_unexpected", 1, 0);
          else begin
            p = port_q.pop_front();
            check_eq("grant_port", {31'd0, mi.if_valid}, {31'd0, p});
          end
        end
        if (mi.if_valid === 1'b1) begin
          if_valid_cnt++;
          if (if_q.size() == 0) check_eq("if_unexpected", 1, 0);
          else begin
            e = if_q.pop_front();
            check_eq("if_rdata", mi.if_rdata, e);
          end
        end
        if (mi.dm_valid === 1'b1) begin
          dm_valid_cnt++;
          if (dm_q.size() == 0) check_eq("dm_unexpected", 1, 0);
          else begin
            d = dm_q.pop_front();
            check_eq("dm_err", {31'd0, mi.dm_err}, {31'd0, d.err});
            if (d.chk_rd) check_eq("dm_rdata", mi.dm_rdata, d.rdata);
          end
        end
      end
    end
  end

  task automatic wait_port(input bit is_if, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_if ? (mi.if_valid === 1'b1) : (mi.dm_valid === 1'b1)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq(is_if ? "if_timeout" : "dm_timeout", 0, 1);
  endtask

  task automatic dm_op(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rw, input logic [31:0] exp_rd,
                       input logic err, input logic [3:0] strb, input logic [31:0] exp_wd);
    dm_t  d;
    bus_t b;
    bit   seen;
    rd_word  = rw;
    d.err    = err;
    d.rdata  = exp_rd;
    d.chk_rd = err || !we;
    dm_q.push_back(d);
    port_q.push_back(1'b0);
    if (!err) begin
      b.addr   = {addr[31:2], 2'b00};
      b.we     = we;
      b.strb   = strb;
      b.wdata  = exp_wd;
      b.chk_wd = we;
      bus_q.push_back(b);
    end
    mi.dm_we    = we;
    mi.dm_type  = ty;
    mi.dm_addr  = addr;
    mi.dm_wdata = wd;
    mi.dm_req   = 1'b1;
    wait_port(1'b0, seen);
    mi.dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] rw);
    bus_t b;
    bit   seen;
    rd_word = rw;
    if_q.push_back(rw);
    port_q.push_back(1'b1);
    b.addr = {addr[31:2], 2'b00}; b.we = 1'b0; b.strb = 4'b0000; b.wdata = '0; b.chk_wd = 1'b0;
    bus_q.push_back(b);
    mi.if_addr = addr;
    mi.if_req  = 1'b1;
    @(negedge clk);
    check_eq("if_stall_wait", {31'd0, mi.if_stall}, 32'd1);
    wait_port(1'b1, seen);
    check_eq("if_stall_done", {31'd0, mi.if_stall}, 32'd0);
    mi.if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus_t b;
    bit   seen;
    int   c;
    bit   pat[10];
    rstn = 1'b0;
    mi.if_req = 1'b1; mi.if_addr = '0; mi.if_flush = 1'b0;
    mi.dm_req = 1'b1; mi.dm_we = 1'b0; mi.dm_type = 3'b010; mi.dm_addr = '0; mi.dm_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_mem_req", {31'd0, mi.mem_req}, 32'd0);
    check_eq("rst_if_valid", {31'd0, mi.if_valid}, 32'd0);
    check_eq("rst_dm_valid", {31'd0, mi.dm_valid}, 32'd0);
    check_eq("rst_if_stall", {31'd0, mi.if_stall}, 32'd0);
    check_eq("rst_dm_stall", {31'd0, mi.dm_stall}, 32'd0);
    check_eq("rst_mem_wstrb", {28'd0, mi.mem_wstrb}, 32'd0);
    mi.if_req = 1'b0; mi.dm_req = 1'b0;
    rstn = 1'b1;
    @(negedge clk);

    // fetch alone, ack two cycles after mem_req
    ack_delay = 2;
    fetch(32'h0000_0010, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    check_eq("if_valid_once", if_valid_cnt, 1);

    // stores: lane replication and strobes
    ack_delay = 0;
    dm_op(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, '0, '0, 1'b0, 4'b1000, 32'hABAB_ABAB);
    dm_op(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, '0, '0, 1'b0, 4'b1100, 32'h1234_1234);
    dm_op(1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, '0, '0, 1'b0, 4'b1111, 32'hCAFE_F00D);

    // loads: sign/zero extension
    ack_delay = 1;
    dm_op(1'b0, 3'b001, 32'h0000_0102, '0, 32'h80F0_1234, 32'hFFFF_80F0, 1'b0, 4'b0000, '0);
    dm_op(1'b0, 3'b101, 32'h0000_0102, '0, 32'h80F0_1234, 32'h0000_80F0, 1'b0, 4'b0000, '0);
    dm_op(1'b0, 3'b000, 32'h0000_0101, '0, 32'h80F0_1234, 32'h0000_0012, 1'b0, 4'b0000, '0);
    dm_op(1'b0, 3'b000, 32'h0000_0103, '0, 32'h80F0_1234, 32'hFFFF_FF80, 1'b0, 4'b0000, '0);
    dm_op(1'b0, 3'b100, 32'h0000_0103, '0, 32'h80F0_1234, 32'h0000_0080, 1'b0, 4'b0000, '0);
    dm_op(1'b0, 3'b010, 32'h0000_0100, '0, 32'h80F0_1234, 32'h80F0_1234, 1'b0, 4'b0000, '0);

    // misaligned accesses never reach the bus
    c = mem_req_cycles;
    seen = 1'b0;
    dm_op(1'b1, 3'b010, 32'h0000_0102, 32'h5555_AAAA, '0, '0, 1'b1, 4'b0000, '0);
    dm_op(1'b0, 3'b001, 32'h0000_0101, '0, 32'h1111_2222, '0, 1'b1, 4'b0000, '0);
    check_eq("misaligned_no_req", mem_req_cycles - c, 0);

    // contention: four data grants then one fetch, repeating
    ack_delay = 0;
    rd_word = 32'h1357_2468;
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int k = 0; k < 10; k++) begin
      port_q.push_back(pat[k]);
      if (pat[k]) begin
        if_q.push_back(32'h1357_2468);
        b.addr = 32'h0000_0080; b.we = 1'b0; b.strb = 4'b0000; b.wdata = '0; b.chk_wd = 1'b0;
      end else begin
        dm_q.push_back('{err: 1'b0, rdata: 32'h1357_2468, chk_rd: 1'b1});
        b.addr = 32'h0000_0300; b.we = 1'b0; b.strb = 4'b0000; b.wdata = '0; b.chk_wd = 1'b0;
      end
      bus_q.push_back(b);
    end
    mi.if_addr = 32'h0000_0080;
    mi.dm_we = 1'b0; mi.dm_type = 3'b010; mi.dm_addr = 32'h0000_0300;
    mi.if_req = 1'b1; mi.dm_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        seen = (mi.if_valid === 1'b1) || (mi.dm_valid === 1'b1);
      end
      if (!seen) begin
        check_eq("contention_timeout", 0, 1);
        break;
      end
    end
    mi.if_req = 1'b0; mi.dm_req = 1'b0;
    @(negedge clk);

    // flush while the fetch is in flight
    ack_delay = 2;
    c = if_valid_cnt;
    b.addr = 32'h0000_0040; b.we = 1'b0; b.strb = 4'b0000; b.wdata = '0; b.chk_wd = 1'b0;
    bus_q.push_back(b);
    mi.if_addr = 32'h0000_0040;
    mi.if_req  = 1'b1;
    @(negedge clk);
    check_eq("flush_inflight_req", {31'd0, mi.mem_req}, 32'd1);
    mi.if_flush = 1'b1;
    @(negedge clk);
    mi.if_flush = 1'b0;
    mi.if_req   = 1'b0;
    dm_op(1'b0, 3'b010, 32'h0000_0500, '0, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0, 4'b0000, '0);
    check_eq("flush_no_if_valid", if_valid_cnt - c, 0);

    // reset mid data transaction
    ack_delay = 20;
    mi.dm_we = 1'b0; mi.dm_type = 3'b010; mi.dm_addr = 32'h0000_0600;
    mi.dm_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (mi.mem_req === 1'b1);
    end
    check_eq("rst_setup_mem_req", {31'd0, seen}, 32'd1);
    rstn = 1'b0;
    #1;
    check_eq("rst_async_mem_req", {31'd0, mi.mem_req}, 32'd0);
    check_eq("rst_async_mem_addr", mi.mem_addr, 32'd0);
    check_eq("rst_async_dm_stall", {31'd0, mi.dm_stall}, 32'd0);
    mi.dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("post_rst_idle", {31'd0, mi.mem_req}, 32'd0);
    ack_delay = 0;
    dm_op(1'b0, 3'b010, 32'h0000_0604, '0, 32'h1122_3344, 32'h1122_3344, 1'b0, 4'b0000, '0);

    repeat (2) @(negedge clk);
    check_eq("queues_empty", bus_q.size() + dm_q.size() + if_q.size() + port_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
